ring_monitor: RTL

Receive-side checker for the ring counter. Samples a WIDTH-bit ring pattern every clock, verifies that it advances by one rotate-right per cycle, locks after LOCK_N consecutive correct advances, and flags each break in the sequence. It also decodes a one-hot ring into a binary index. It sits downstream of ring_counter, on its count bus, as a self-check and status source.

---
 rtl/ring_pkg.sv | 36 +++
 rtl/ring_idx_enc.sv | 35 +++
 rtl/ring_monitor.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring sequence monitor.
// State encodings, rotate-right helper and index-width helper.
package ring_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam int MAX_W  = 64;
    localparam int RING_W = 4;

    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int IDX_W = idx_width(RING_W);

    // Rotate-right of the low w bits of x; bits at and above w read as 0.
    function automatic logic [MAX_W-1:0] rot(
        input logic [MAX_W-1:0] x,
        input int               w
    );
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i == w - 1)
                r[i] = x[0];
            else if (i < w - 1)
                r[i] = x[(i + 1) % MAX_W];
        end
        return r;
    endfunction

endpackage

// File: rtl/ring_idx_enc.sv
// Combinational one-hot to binary encoder for the ring monitor.
// idx_o is forced to 0 whenever the input is not exactly one-hot.
module ring_idx_enc
    import ring_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IW    = 2
) (
    input  logic [WIDTH-1:0] ring_i,
    output logic [IW-1:0]    idx_o,
    output logic             onehot_o
);

    logic [IW-1:0] acc;
    logic          single;

    always_comb begin
        single = (ring_i != '0) &&
                 ((ring_i & (ring_i - WIDTH'(1))) == '0);
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ring_i[i])
                acc = acc | IW'(i);
        end
    end

    always_comb begin
        onehot_o = single;
        idx_o    = single ? acc : '0;
    end

endmodule

// File: rtl/ring_monitor.sv
// Receive-side ring counter checker: lock, break detection, index decode.
// Define RING_MON_ERRCNT_EN to build the saturating error counter.
module ring_monitor
    import ring_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int LOCK_N = 2,
    parameter int CNT_W  = 8
) (
    input  logic                        clk,
    input  logic                        clr_n,
    input  logic [WIDTH-1:0]            ring,
    input  logic                        resync,
    output logic                        locked,
    output logic                        err,
    output logic [CNT_W-1:0]            err_cnt,
    output logic [idx_width(WIDTH)-1:0] idx,
    output logic                        onehot
);

    localparam int IW   = idx_width(WIDTH);
    localparam int MC_W = (LOCK_N > 0) ? $clog2(LOCK_N + 1) : 1;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  prev_q, prev_d;
    logic [MC_W-1:0]   mcnt_q, mcnt_d;
    logic [MC_W-1:0]   mcnt_inc;
    logic              err_q, err_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              onehot_q, onehot_d;
    logic              match;

    ring_idx_enc #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_enc (
        .ring_i   (ring),
        .idx_o    (idx_d),
        .onehot_o (onehot_d)
    );

    // Comparison done at full helper width; upper bits are zero on both sides.
    assign match    = (MAX_W'(ring) == rot(MAX_W'(prev_q), WIDTH));
    assign mcnt_inc = mcnt_q + MC_W'(1);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= IDLE;
            prev_q   <= '0;
            mcnt_q   <= '0;
            err_q    <= 1'b0;
            idx_q    <= '0;
            onehot_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            mcnt_q   <= mcnt_d;
            err_q    <= err_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
        end
    end

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        mcnt_d  = mcnt_q;
        err_d   = 1'b0;
        if (ring == '0) begin
            state_d = IDLE;
            mcnt_d  = '0;
            err_d   = (state_q == LOCKED);
        end else if (resync) begin
            prev_d  = ring;
            mcnt_d  = '0;
            state_d = HUNT;
        end else begin
            prev_d = ring;
            unique case (state_q)
                IDLE: begin
                    mcnt_d  = '0;
                    state_d = HUNT;
                end
                HUNT: begin
                    if (match) begin
                        mcnt_d = mcnt_inc;
                        if (mcnt_inc == MC_W'(LOCK_N))
                            state_d = LOCKED;
                    end else begin
                        mcnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (!match) begin
                        err_d   = 1'b1;
                        mcnt_d  = '0;
                        state_d = HUNT;
                    end
                end
                default: begin
                    mcnt_d  = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        locked = (state_q == LOCKED);
        err    = err_q;
        idx    = idx_q;
        onehot = onehot_q;
    end

`ifdef RING_MON_ERRCNT_EN
    logic [CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            err_cnt_q <= '0;
        else if (err_d && (err_cnt_q != '1))
            err_cnt_q <= err_cnt_q + CNT_W'(1);
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule
